// File: rtl/mealy_pkg.sv
// Shared state encodings for the Mealy detector path: the serializer FSM and the detector's
// QA/QB states use the same one-bit encoding.
package mealy_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam logic QA = 1'b0;
    localparam logic QB = 1'b1;

    typedef enum logic {
        StIdle  = ST_IDLE,
        StShift = ST_SHIFT
    } ser_state_e;

endpackage

// File: rtl/mealy_bit_serializer.sv
// Parallel-to-serial feeder for the Mealy detector: valid/ready word input, one-word holding
// register for gap-free streaming, registered serial output with bit_valid/frame_start qualifiers.
module mealy_bit_serializer
    import mealy_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             x_q, x_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             accept;
    logic [CW-1:0]    bit_idx;

    assign in_ready = !rst && !hold_valid_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q != LAST) begin
                    cnt_d = cnt_q + 1'b1;
                    if (accept) begin
                        hold_d       = in_data;
                        hold_valid_d = 1'b1;
                    end
                end else if (hold_valid_q) begin
                    shift_d      = hold_q;
                    hold_valid_d = 1'b0;
                    cnt_d        = '0;
                end else if (accept) begin
                    // Hold is empty on the last bit: bypass it so the stream stays contiguous.
                    shift_d = in_data;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from next state so they come straight out of flops.
    always_comb begin
        bit_idx       = MSB_FIRST ? (LAST - cnt_d) : cnt_d;
        bit_valid_d   = (state_d == StShift);
        frame_start_d = (state_d == StShift) && (cnt_d == '0);
        x_d           = (state_d == StShift) ? shift_d[bit_idx] : IDLE_LEVEL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            shift_q       <= '0;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            x_q           <= IDLE_LEVEL;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            x_q           <= x_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x_out       = x_q;
    assign bit_valid   = bit_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q == StShift) || hold_valid_q;

endmodule

// File: tb/tb_mealy_bit_serializer.sv
// Bench for mealy_bit_serializer: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a bit-queue model of the expected serial stream.
module tb_mealy_bit_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;

    logic ra, xa, bva, fsa, busya;
    logic rb, xb, bvb, fsb, busyb;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int bv_cnt = 0;
    int fs_times[$];
    bit qa[$];
    bit qb[$];
    bit qf[$];
    bit last_acc = 1'b0;
    logic [15:0] ha = '0;
    logic [15:0] hb = '0;

    always #5 clk = ~clk;

    mealy_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ra),
        .x_out(xa), .bit_valid(bva), .frame_start(fsa), .busy(busya)
    );

    mealy_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rb),
        .x_out(xb), .bit_valid(bvb), .frame_start(fsb), .busy(busyb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Words accepted whose first bit has not yet appeared on the line.
    function automatic int pending();
        int n = 0;
        for (int i = 1; i < qf.size(); i++) if (qf[i]) n++;
        return n;
    endfunction

    // Called at a falling edge: drive inputs, check this cycle, advance model over next edge.
    task automatic cycle(input bit r, input bit v, input logic [7:0] d);
        bit rdy_exp;
        bit any;
        rst = r; in_valid = v; in_data = d;
        #1;
        any     = (qa.size() > 0);
        rdy_exp = !r && (pending() == 0);
        chk("in_ready_msb", ra, rdy_exp);
        chk("in_ready_lsb", rb, rdy_exp);
        chk("x_out_msb", xa, any ? qa[0] : 1'b0);
        chk("x_out_lsb", xb, any ? qb[0] : 1'b0);
        chk("bit_valid_msb", bva, any);
        chk("bit_valid_lsb", bvb, any);
        chk("frame_start_msb", fsa, any && qf[0]);
        chk("frame_start_lsb", fsb, any && qf[0]);
        chk("busy_msb", busya, any);
        chk("busy_lsb", busyb, any);
        ha = {ha[14:0], xa};
        hb = {hb[14:0], xb};
        if (bva === 1'b1) bv_cnt++;
        if (fsa === 1'b1) fs_times.push_back(cyc);
        last_acc = !r && v && rdy_exp;
        if (r) begin
            qa.delete(); qb.delete(); qf.delete();
        end else begin
            if (any) begin
                void'(qa.pop_front()); void'(qb.pop_front()); void'(qf.pop_front());
            end
            if (last_acc) begin
                for (int i = 0; i < 8; i++) begin
                    qa.push_back(d[7-i]);
                    qb.push_back(d[i]);
                    qf.push_back(i == 0);
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] words[3];
        int idx;
        int guard;
        words[0] = 8'h12; words[1] = 8'hE7; words[2] = 8'h5A;

        @(negedge clk);
        // Reset held two cycles, then released.
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // Single MSB-first word.
        fs_times.delete();
        cycle(1'b0, 1'b1, 8'b1011_0010);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 8'($urandom));
        chk("t2_stream", ha[7:0], 8'b1011_0010);
        chk("t2_frame_count", fs_times.size(), 1);
        cycle(1'b0, 1'b0, 8'h00);
        chk("t2_busy_after", busya, 1'b0);

        // Back-to-back words through the holding register.
        bv_cnt = 0;
        fs_times.delete();
        cycle(1'b0, 1'b1, 8'hA5);
        cycle(1'b0, 1'b1, 8'h3C);
        chk("t3_second_accepted", last_acc, 1'b1);
        for (int i = 0; i < 7; i++) begin
            chk("t3_ready_low", ra, 1'b0);
            cycle(1'b0, 1'b0, 8'hFF);
        end
        chk("t3_ready_back", ra, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00);
        chk("t3_bit_count", bv_cnt, 16);
        chk("t3_frame_count", fs_times.size(), 2);
        if (fs_times.size() == 2) chk("t3_frame_gap", fs_times[1] - fs_times[0], 8);

        // in_valid held high across three queued words.
        bv_cnt = 0;
        idx = 0;
        guard = 0;
        while (idx < 3 && guard < 100) begin
            cycle(1'b0, 1'b1, words[idx]);
            if (last_acc) idx++;
            guard++;
        end
        chk("t4_all_accepted", idx, 3);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 8'h00);
        chk("t4_bit_count", bv_cnt, 24);

        // Reset in the middle of a word with the hold register occupied.
        cycle(1'b0, 1'b1, 8'hFF);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        chk("t5_x_after_rst", xa, 1'b0);
        chk("t5_bv_after_rst", bva, 1'b0);
        chk("t5_busy_after_rst", busya, 1'b0);
        cycle(1'b0, 1'b1, 8'hC3);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 8'h00);
        chk("t5_new_word", ha[7:0], 8'hC3);

        // LSB-first instance.
        cycle(1'b0, 1'b1, 8'b0000_0110);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 8'($urandom));
        chk("t6_lsb_stream", hb[7:0], 8'b0110_0000);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, 8'($urandom));
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
